// File: rtl/a51_pkg.sv
// Shared definitions for the A5/1 cipher streamer: FSM state type and
// message/keystream sizing constants.
package a51_pkg;

  localparam int A51_MSG_BYTES = 28;
  localparam int A51_KS_BITS   = 224;
  localparam int A51_BYTE_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } a51_state_t;

endpackage

// File: rtl/a51_cipher_streamer_if.sv
// Ciphertext byte stream toward the LCD character driver.
// Handshake: a byte transfers on a rising clock edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the master holds
// out_byte stable. out_valid does not depend on out_ready.
interface a51_cipher_streamer_if;
  import a51_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [A51_BYTE_W-1:0] out_byte;

  modport master (output out_valid, output out_byte, input out_ready);
  modport slave  (input out_valid, input out_byte, output out_ready);

endinterface

// File: rtl/a51_byte_fifo.sv
// Small synchronous byte FIFO with first-word-visible read data.
// A push on a full FIFO only succeeds when a pop happens in the same cycle.
// flush empties the FIFO and has priority over push/pop.
module a51_byte_fifo
  import a51_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [A51_BYTE_W-1:0]   din,
  output logic [A51_BYTE_W-1:0]   dout,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [A51_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  // Empty FIFO presents zero so the output bus is quiet between bursts.
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/a51_cipher_streamer.sv
// A5/1 ciphertext streamer: packs the serial keystream into bytes, XORs each
// with the matching message byte and streams the result out through a small
// FIFO. Optional macro A51_CIPHER_BYTECOUNT_EN adds a saturating count of
// delivered bytes on sent_count.
module a51_cipher_streamer
  import a51_pkg::*;
#(
  parameter int MSG_BYTES  = A51_MSG_BYTES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    ks_valid,
  input  logic                    ks_bit,
  output logic [4:0]              msg_index,
  input  logic [A51_BYTE_W-1:0]   msg_byte,
  a51_cipher_streamer_if.master   stream,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
`ifdef A51_CIPHER_BYTECOUNT_EN
  output logic [5:0]              sent_count,
`endif
  output a51_state_t              state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  a51_state_t            state;
  a51_state_t            next_state;
  logic [2:0]            bit_cnt;
  logic [4:0]            byte_idx;
  logic [6:0]            shift;
  logic                  pop_fire;
  logic                  byte_done;
  logic                  push;
  logic                  last_byte;
  logic [A51_BYTE_W-1:0] push_byte;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;

  assign msg_index        = byte_idx;
  assign state_dbg        = state;
  assign stream.out_valid = ~fifo_empty;
  assign pop_fire         = ~fifo_empty & stream.out_ready;
  assign byte_done        = (state == COLLECT) & ks_valid & (bit_cnt == 3'd7);
  assign push             = byte_done & ~start;
  assign last_byte        = (byte_idx == 5'(MSG_BYTES - 1));
  assign push_byte        = {shift, ks_bit} ^ msg_byte;

  a51_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (start),
    .push  (push),
    .pop   (pop_fire),
    .din   (push_byte),
    .dout  (stream.out_byte),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next state; start re-arms from any state and wins over everything.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = COLLECT;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        COLLECT: if (byte_done && last_byte) next_state = DRAIN;
        DRAIN:   if (fifo_empty || (fifo_count == CW'(1) && pop_fire)) next_state = DONE;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      COLLECT, DRAIN: busy = 1'b1;
      DONE:           done = 1'b1;
      default:        ;
    endcase
  end

  // Bit packing, byte index and sticky overflow; a dropped byte still advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      bit_cnt  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      overflow <= 1'b0;
    end else if (state == COLLECT && ks_valid) begin
      shift   <= {shift[5:0], ks_bit};
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        byte_idx <= byte_idx + 5'd1;
        if (fifo_full && !pop_fire) overflow <= 1'b1;
      end
    end
  end

`ifdef A51_CIPHER_BYTECOUNT_EN
  // Saturating count of bytes handed to the LCD path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              sent_count <= '0;
    else if (start)                         sent_count <= '0;
    else if (pop_fire && sent_count != 6'd63) sent_count <= sent_count + 6'd1;
  end
`endif

endmodule

// File: tb/tb_a51_cipher_streamer.sv
// Bench for a51_cipher_streamer. Builds with or without A51_CIPHER_BYTECOUNT_EN.
// Reference model: a queue of expected ciphertext bytes plus a run phase,
// updated once per clock from the stimulus.
module tb_a51_cipher_streamer;
  import a51_pkg::*;

  localparam int DEPTH = 4;
  localparam int NB    = 28;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ks_valid;
  logic       ks_bit;
  logic [4:0] msg_index;
  logic [7:0] msg_byte;
  logic       busy;
  logic       done;
  logic       overflow;
  a51_state_t state_dbg;
`ifdef A51_CIPHER_BYTECOUNT_EN
  logic [5:0] sent_count;
`endif

  logic [7:0] msg_mem [32];
  assign msg_byte = msg_mem[msg_index];

  a51_cipher_streamer_if stream_if ();

  a51_cipher_streamer #(.MSG_BYTES(NB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ks_valid   (ks_valid),
    .ks_bit     (ks_bit),
    .msg_index  (msg_index),
    .msg_byte   (msg_byte),
    .stream     (stream_if),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
`ifdef A51_CIPHER_BYTECOUNT_EN
    .sent_count (sent_count),
`endif
    .state_dbg  (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard and model state
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  a51_state_t m_st;
  int         m_bytes;
  int         m_bits;
  logic [7:0] m_acc;
  logic       m_ovf;
  int         m_sent;

  typedef struct {
    logic [7:0] msg;
    logic [7:0] ks;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_st = IDLE; m_bytes = 0; m_bits = 0; m_acc = 8'h00; m_ovf = 1'b0; m_sent = 0;
  endtask

  // One clock of specified behaviour.
  task automatic model_edge(input logic st, input logic kv, input logic kb, input logic rdy);
    a51_state_t pre;
    logic [7:0] b;
    if (st) begin
      model_reset();
      m_st = COLLECT;
      return;
    end
    pre = m_st;
    if (rdy && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (m_sent < 63) m_sent++;
    end
    if (pre == DRAIN && exp_q.size() == 0) m_st = DONE;
    if (pre == COLLECT && kv) begin
      m_acc = {m_acc[6:0], kb};
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        b = m_acc ^ msg_mem[m_bytes];
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else m_ovf = 1'b1;
        m_bytes++;
        if (m_bytes == NB) m_st = DRAIN;
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(stream_if.out_valid), 32'(exp_q.size() != 0));
    chk("out_byte",  32'(stream_if.out_byte),  32'(exp_q.size() != 0 ? exp_q[0] : 8'h00));
    chk("msg_index", 32'(msg_index), 32'(m_bytes % 32));
    chk("busy",      32'(busy),      32'(m_st == COLLECT || m_st == DRAIN));
    chk("done",      32'(done),      32'(m_st == DONE));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("state",     32'(state_dbg), 32'(m_st));
`ifdef A51_CIPHER_BYTECOUNT_EN
    chk("sent_count", 32'(sent_count), 32'(m_sent));
`endif
  endtask

  // Driver: apply inputs mid-cycle, clock, then check 1 time unit after the edge.
  task automatic step(input logic st, input logic kv, input logic kb, input logic rdy);
    start = st; ks_valid = kv; ks_bit = kb; stream_if.out_ready = rdy;
    if (!st && rdy && stream_if.out_valid) got_q.push_back(stream_if.out_byte);
    model_edge(st, kv, kb, rdy);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic feed_bits(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), rdy);
  endtask

  initial begin
    int pops;
    int budget;
    logic [7:0] kbits;

    reset = 1'b1; start = 1'b0; ks_valid = 1'b0; ks_bit = 1'b0; stream_if.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) msg_mem[i] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;

    // Table vectors: one byte with known message and keystream bits (MSB first).
    vecs[0] = '{msg: 8'h00, ks: 8'hA5, exp: 8'hA5};
    vecs[1] = '{msg: 8'hFF, ks: 8'hA5, exp: 8'h5A};
    vecs[2] = '{msg: 8'h3C, ks: 8'h0F, exp: 8'h33};
    vecs[3] = '{msg: 8'h12, ks: 8'hFF, exp: 8'hED};
    vecs[4] = '{msg: 8'h80, ks: 8'h01, exp: 8'h81};
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 32; i++) msg_mem[i] = vecs[v].msg;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int b = 7; b >= 0; b--) step(1'b0, 1'b1, vecs[v].ks[b], 1'b0);
      chk("vec_valid", 32'(stream_if.out_valid), 32'd1);
      chk("vec_byte", 32'(stream_if.out_byte), 32'(vecs[v].exp));
    end

    // Full run: zero keystream, message 0..27, sink always ready.
    for (int i = 0; i < 32; i++) msg_mem[i] = 8'(i);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    got_q.delete();
    for (int i = 0; i < 8 * NB; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    budget = 0;
    while (!done && budget < 10) begin step(1'b0, 1'b0, 1'b0, 1'b1); budget++; end
    chk("full_count", 32'(got_q.size()), 32'(NB));
    for (int i = 0; i < NB && i < got_q.size(); i++) chk("full_byte", 32'(got_q[i]), 32'(i));
    chk("full_done", 32'(done), 32'd1);
    chk("full_ovf", 32'(overflow), 32'd0);

    // Backpressure: sink never ready during collection.
    for (int i = 0; i < 32; i++) msg_mem[i] = 8'($urandom_range(0, 255));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed_bits(32, 1'b0);
    chk("bp_ovf_before", 32'(overflow), 32'd0);
    feed_bits(8, 1'b0);
    chk("bp_ovf_fifth", 32'(overflow), 32'd1);
    feed_bits(8 * NB - 40, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_drain", 32'(state_dbg), 32'(DRAIN));
    got_q.delete();
    pops = 0;
    budget = 0;
    while (!done && budget < 10) begin
      if (stream_if.out_valid) pops++;
      step(1'b0, 1'b1, 1'b1, 1'b1);
      budget++;
    end
    chk("bp_pops", 32'(pops), 32'd4);
    chk("bp_done", 32'(done), 32'd1);

    // Push onto a full FIFO with a same-cycle pop.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed_bits(39, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_valid", 32'(stream_if.out_valid), 32'd1);
    feed_bits(8 * NB - 40, 1'b1);
    budget = 0;
    while (!done && budget < 10) begin step(1'b0, 1'b0, 1'b0, 1'b1); budget++; end
    chk("pp_done", 32'(done), 32'd1);

    // Restart mid-run with 2 bytes buffered after byte 10.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    feed_bits(64, 1'b1);
    feed_bits(16, 1'b0);
    chk("rs_before_valid", 32'(stream_if.out_valid), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rs_valid", 32'(stream_if.out_valid), 32'd0);
    chk("rs_index", 32'(msg_index), 32'd0);
    chk("rs_ovf", 32'(overflow), 32'd0);
    kbits = 8'($urandom_range(0, 255));
    for (int b = 7; b >= 0; b--) step(1'b0, 1'b1, kbits[b], 1'b0);
    chk("rs_byte", 32'(stream_if.out_byte), 32'(kbits ^ msg_mem[0]));

    // Asynchronous reset between edges during collection.
    feed_bits(20, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(stream_if.out_valid), 32'd0);
    chk("ar_byte", 32'(stream_if.out_byte), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_ovf", 32'(overflow), 32'd0);
    chk("ar_index", 32'(msg_index), 32'd0);
    #1 reset = 1'b0;
    model_reset();
    feed_bits(12, 1'b1);
    chk("ar_idle", 32'(state_dbg), 32'(IDLE));

    // Randomized runs: random qualifier, sink readiness and rare restarts.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) msg_mem[i] = 8'($urandom_range(0, 255));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      budget = 0;
      while (!done && budget < 1500) begin
        step(1'($urandom_range(0, 400) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
        budget++;
      end
      chk("rnd_done", 32'(done), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/a51_cipher_streamer.md
Name: a51_cipher_streamer

Overview:
- Sits directly downstream of the A5/1 keystream generator and upstream of the LCD character driver.
- Packs the serial keystream (one bit per qualified cycle) into bytes and XORs each byte with the matching stored message byte.
- Buffers the resulting ciphertext in a small FIFO and hands it to the LCD path over a valid/ready handshake.
- Replaces the 224-bit aggregate register, the XOR register and the wide byte mux with a byte-serial pipeline.

Parameters:
- MSG_BYTES, 28, number of message/ciphertext bytes per run (224 bits).
- FIFO_DEPTH, 4, ciphertext byte FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse (keystream-gen switch edge); clears and arms the block.
- ks_valid  in  1  keystream bit qualifier (KeyStreamReady & ~KeyStreamDepleted).
- ks_bit  in  1  keystream bit from the generator.
- msg_index  out  5  byte index into the message store; combinational read.
- msg_byte  in  8  message byte at msg_index, valid in the same cycle.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  LCD driver accepts a byte this cycle.
- out_byte  out  8  FIFO head byte.
- busy  out  1  state is COLLECT or DRAIN.
- done  out  1  all MSG_BYTES bytes delivered; level signal.
- overflow  out  1  sticky; a completed byte found the FIFO full.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE; bit_cnt=0, byte_idx=0, shift=0, FIFO empty.
  - out_valid=0, out_byte=0, busy=0, done=0, overflow=0, msg_index=0.
- States: IDLE, COLLECT, DRAIN, DONE.
- start:
  - Valid in any state.
  - On the next edge: clears counters, FIFO and overflow, then enters COLLECT. Any in-flight FIFO contents are discarded.
  - start has priority over all other events in the same cycle.
- Bit collection (COLLECT only):
  - On ks_valid: shift <= {shift[6:0], ks_bit} and bit_cnt increments.
  - The first keystream bit of a byte ends up in bit 7.
- Byte completion:
  - When ks_valid and bit_cnt==7, the byte {shift[6:0], ks_bit} ^ msg_byte is pushed into the FIFO on the same edge.
  - Then bit_cnt wraps to 0 and byte_idx increments.
  - msg_index = byte_idx at all times.
- Push on full FIFO:
  - If a pop occurs in the same cycle, the push succeeds.
  - Otherwise the byte is dropped, overflow is set, and byte_idx still advances. The keystream cannot be stalled.
- End of collection:
  - When the push of byte MSG_BYTES-1 occurs, go to DRAIN.
  - In DRAIN, ks_valid is ignored.
- DRAIN -> DONE on the edge where the FIFO becomes empty.
- DONE:
  - done=1.
  - Holds until start or reset.
  - ks_valid is ignored.
- IDLE: ks_valid is ignored.
- Output handshake:
  - A byte transfers when out_valid & out_ready.
  - out_byte is stable while out_valid=1 and out_ready=0.
  - FIFO read latency: a pushed byte appears on out_byte the cycle after the push edge (registered FIFO, first-word visible).
- Occupancy: a simultaneous push and pop leaves the count unchanged. Count width is clog2(FIFO_DEPTH)+1.
- busy = (state==COLLECT) | (state==DRAIN).

Optional Feature:
- Macro: A51_CIPHER_BYTECOUNT_EN.
- When defined:
  - Adds output port sent_count [5:0], which counts handshaked bytes.
  - Cleared by reset and by start.
  - Saturates at 63.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package a51_pkg holds:
  - The state enum (IDLE, COLLECT, DRAIN, DONE).
  - A51_MSG_BYTES=28 and A51_KS_BITS=224.
  - The byte width constant 8.
- One sub-module: a51_byte_fifo (synchronous FIFO, DEPTH parameter).
  - Ports: push, pop, din, dout, empty, full, flush.
  - flush is driven by start.

Test Plan:
- Basic XOR with bit order:
  - start; msg_byte=0x00 for all indices; keystream bits 1,0,1,0,0,1,0,1 -> first out_byte=0xA5 one cycle after the 8th bit.
  - With msg_byte=0xFF and the same bits -> 0x5A.
- Full run:
  - 224 ks_valid cycles; out_ready held at 1; message bytes 0x00..0x1B; keystream all zeros.
  - -> 28 bytes out equal to 0x00..0x1B in order.
  - -> done=1 after the last pop; overflow=0; msg_index sequence 0..27.
- Backpressure:
  - out_ready=0 throughout the run; FIFO_DEPTH=4.
  - -> first 4 bytes are held, overflow=1 at the 5th completion, and state stays DRAIN after the 28th byte.
  - Then raise out_ready -> exactly 4 bytes drain, then done=1.
- Push and pop on full:
  - FIFO full; out_ready=1 in the same cycle a byte completes.
  - -> no overflow, occupancy stays 4, byte order is preserved.
- Restart mid-run:
  - start asserted after 10 bytes with 2 bytes in the FIFO.
  - -> next cycle out_valid=0, msg_index=0, overflow=0.
  - The following 8 bits produce a byte using msg_byte[0].
- Asynchronous reset:
  - reset pulsed between clock edges during COLLECT.
  - -> all outputs go to 0 immediately, without waiting for a clock edge.
  - ks_valid is ignored until start.
